mac_layer_sched: RTL and testbench

- Scheduler for a dense layer that shares one fixed-point multiply/add pair across all N_OUT neurons of the layer.
- On start, it latches x, w and b, then walks rows and columns with counters.
- For each row it feeds one x·w product per cycle into a registered accumulator seeded with that row's bias, and writes the finished sum to y.
- It sits between the layer-level controller (start/done handshake) and the next activation stage.

---
 rtl/mac_layer_sched_pkg.sv | 34 +++
 rtl/mac_layer_sched_if.sv | 40 ++++
 rtl/fixed_point_add.sv | 19 +
 rtl/fixed_point_multiply.sv | 23 ++
 rtl/mac_layer_sched_mac_pipe.sv | 65 ++++++
 rtl/mac_layer_sched.sv | 186 ++++++++++++++++++
 tb/tb_mac_layer_sched.sv | 244 ++++++++++++++++++++++++
 7 files changed

// File: rtl/mac_layer_sched_pkg.sv
// ---------------------------------------------------------------------------
// mac_layer_sched_pkg
// Shared definitions for the dense-layer MAC scheduler: FSM state encoding,
// default element width, fixed-point fraction position and a clog2 helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mac_layer_sched_pkg;

  localparam int DEF_BITSIZE = 20;
  // Binary point position of every fixed-point element (Q(BITSIZE-12).12).
  localparam int FRAC_BITS   = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Number of bits needed to hold values 0..value-1; 0 for value<=1.
  function automatic int clog2(input int value);
    int v;
    int n;
    v = value - 1;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mac_layer_sched_if.sv
// ---------------------------------------------------------------------------
// mac_layer_sched_if
// Handshake and operand/result bus between the layer controller and the
// MAC scheduler.
//   start   : controller -> scheduler, request a layer pass
//   x, w, b : controller -> scheduler, packed input vector, weights, biases
//   busy    : scheduler -> controller, pass in progress
//   done    : scheduler -> controller, one-cycle completion pulse
//   y_valid : scheduler -> next stage, y holds a complete result set
//   y       : scheduler -> next stage, packed results
// Modports: master (controller side), slave (scheduler side).
// ---------------------------------------------------------------------------
interface mac_layer_sched_if
  import mac_layer_sched_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 4
);

  logic                          start;
  logic [BITSIZE*N_IN-1:0]       x;
  logic [BITSIZE*N_IN*N_OUT-1:0] w;
  logic [BITSIZE*N_OUT-1:0]      b;
  logic                          busy;
  logic                          done;
  logic                          y_valid;
  logic [BITSIZE*N_OUT-1:0]      y;

  modport master (
    output start, x, w, b,
    input  busy, done, y_valid, y
  );

  modport slave (
    input  start, x, w, b,
    output busy, done, y_valid, y
  );

endinterface

// File: rtl/fixed_point_add.sv
// ---------------------------------------------------------------------------
// fixed_point_add
// Combinational fixed-point add, two's complement wrap on overflow.
//   i_a, i_b : operands
//   o_s      : sum
// ---------------------------------------------------------------------------
module fixed_point_add
  import mac_layer_sched_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE
) (
  input  logic signed [BITSIZE-1:0] i_a,
  input  logic signed [BITSIZE-1:0] i_b,
  output logic signed [BITSIZE-1:0] o_s
);

  assign o_s = i_a + i_b;

endmodule

// File: rtl/fixed_point_multiply.sv
// ---------------------------------------------------------------------------
// fixed_point_multiply
// Combinational signed fixed-point multiply. Full product is shifted down by
// FRAC_BITS (floor) and wrapped to BITSIZE bits; no saturation.
//   i_a, i_b : signed operands
//   o_p      : signed product
// ---------------------------------------------------------------------------
module fixed_point_multiply
  import mac_layer_sched_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE
) (
  input  logic signed [BITSIZE-1:0] i_a,
  input  logic signed [BITSIZE-1:0] i_b,
  output logic signed [BITSIZE-1:0] o_p
);

  logic signed [2*BITSIZE-1:0] w_full;

  assign w_full = i_a * i_b;
  assign o_p    = BITSIZE'(w_full >>> FRAC_BITS);

endmodule

// File: rtl/mac_layer_sched_mac_pipe.sv
// ---------------------------------------------------------------------------
// mac_layer_sched_mac_pipe
// Shared multiply/add pair with a registered product and accumulator.
// Pure datapath; all sequencing comes from the scheduler.
//   clk, reset_n : clock, async active-low reset
//   i_en         : capture i_x_el*i_w_el into the product register
//   i_seed       : acc <= i_bias (wins over i_accum)
//   i_accum      : acc <= acc + product register
//   i_x_el       : selected input element
//   i_w_el       : selected weight element
//   i_bias       : bias of the current row
//   o_acc        : accumulator value
// ---------------------------------------------------------------------------
module mac_layer_sched_mac_pipe
  import mac_layer_sched_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_en,
  input  logic               i_seed,
  input  logic               i_accum,
  input  logic [BITSIZE-1:0] i_x_el,
  input  logic [BITSIZE-1:0] i_w_el,
  input  logic [BITSIZE-1:0] i_bias,
  output logic [BITSIZE-1:0] o_acc
);

  logic signed [BITSIZE-1:0] w_prod;
  logic signed [BITSIZE-1:0] w_sum;
  logic signed [BITSIZE-1:0] r_prod;
  logic signed [BITSIZE-1:0] r_acc;

  fixed_point_multiply #(.BITSIZE(BITSIZE)) u_mul (
    .i_a (i_x_el),
    .i_b (i_w_el),
    .o_p (w_prod)
  );

  fixed_point_add #(.BITSIZE(BITSIZE)) u_add (
    .i_a (r_acc),
    .i_b (r_prod),
    .o_s (w_sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      if (i_en) begin
        r_prod <= w_prod;
      end
      if (i_seed) begin
        r_acc <= i_bias;
      end else if (i_accum) begin
        r_acc <= w_sum;
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_layer_sched.sv
// ---------------------------------------------------------------------------
// mac_layer_sched
// Dense-layer scheduler: one shared multiply/add serves all N_OUT neurons.
// Latches x/w/b on start, walks rows (r) and columns (k), writes each row
// sum to y and pulses done after the last row.
//   clk     : rising-edge clock
//   reset_n : async active-low reset, aborts any pass
//   bus     : slave side of mac_layer_sched_if (start/x/w/b in,
//             busy/done/y_valid/y out)
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; y and y_valid hold last result
//   S_LOAD  | latch x, w, b; clear r and k
//   S_MAC   | k=0 seed acc with bias, k=1..N_IN accumulate products
//   S_WRITE | y[r] <= acc; next row or finish
//   S_DONE  | one-cycle done pulse, y_valid set
// ---------------------------------------------------------------------------
module mac_layer_sched
  import mac_layer_sched_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mac_layer_sched_if.slave     bus
);

  localparam int KW = clog2(N_IN + 1);
  localparam int RW = (clog2(N_OUT) < 1) ? 1 : clog2(N_OUT);
  localparam logic [KW-1:0] K_LAST = KW'(N_IN);
  localparam logic [RW-1:0] R_LAST = RW'(N_OUT - 1);

  state_t r_state;
  state_t w_next_state;

  logic [KW-1:0]                 r_k;
  logic [RW-1:0]                 r_r;
  logic [BITSIZE*N_IN-1:0]       r_x;
  logic [BITSIZE*N_IN*N_OUT-1:0] r_w;
  logic [BITSIZE*N_OUT-1:0]      r_b;
  logic [BITSIZE*N_OUT-1:0]      r_y;
  logic                          r_y_valid;

  logic               w_en;
  logic               w_seed;
  logic               w_accum;
  logic [BITSIZE-1:0] w_x_el;
  logic [BITSIZE-1:0] w_w_el;
  logic [BITSIZE-1:0] w_bias;
  logic [BITSIZE-1:0] w_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_en         = 1'b0;
    w_seed       = 1'b0;
    w_accum      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next_state = S_MAC;
      end
      S_MAC: begin
        // Product for column k is registered while acc absorbs column k-1.
        w_en    = (r_k != K_LAST);
        w_seed  = (r_k == '0);
        w_accum = (r_k != '0);
        if (r_k == K_LAST) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        w_next_state = (r_r == R_LAST) ? S_DONE : S_MAC;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand selection by decode; at k==N_IN nothing matches and the unused
  // product input is zero.
  always_comb begin
    w_x_el = '0;
    w_w_el = '0;
    w_bias = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (KW'(i) == r_k) begin
        w_x_el = r_x[BITSIZE*i +: BITSIZE];
      end
    end
    for (int rr = 0; rr < N_OUT; rr++) begin
      if (RW'(rr) == r_r) begin
        w_bias = r_b[BITSIZE*rr +: BITSIZE];
        for (int kk = 0; kk < N_IN; kk++) begin
          if (KW'(kk) == r_k) begin
            w_w_el = r_w[BITSIZE*(rr*N_IN+kk) +: BITSIZE];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k       <= '0;
      r_r       <= '0;
      r_x       <= '0;
      r_w       <= '0;
      r_b       <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_y_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          r_x <= bus.x;
          r_w <= bus.w;
          r_b <= bus.b;
          r_k <= '0;
          r_r <= '0;
        end
        S_MAC: begin
          if (r_k != K_LAST) begin
            r_k <= r_k + 1'b1;
          end
        end
        S_WRITE: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (RW'(i) == r_r) begin
              r_y[BITSIZE*i +: BITSIZE] <= w_acc;
            end
          end
          if (r_r != R_LAST) begin
            r_r <= r_r + 1'b1;
            r_k <= '0;
          end
        end
        S_DONE: begin
          r_y_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  mac_layer_sched_mac_pipe #(.BITSIZE(BITSIZE)) u_mac_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_en),
    .i_seed  (w_seed),
    .i_accum (w_accum),
    .i_x_el  (w_x_el),
    .i_w_el  (w_w_el),
    .i_bias  (w_bias),
    .o_acc   (w_acc)
  );

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.y_valid = r_y_valid | (r_state == S_DONE);
  assign bus.y       = r_y;

endmodule

// File: tb/tb_mac_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_mac_layer_sched
// Self-checking bench for mac_layer_sched with an arithmetic reference model
// of the layer (y[r] = b[r] + sum_k x[k]*w[r][k], fixed-point, wrapping).
// Cycle 1 is the LOAD cycle, i.e. the first cycle after start is sampled.
// ---------------------------------------------------------------------------
module tb_mac_layer_sched;
  import mac_layer_sched_pkg::*;

  localparam int BITS     = 20;
  localparam int NI       = 6;
  localparam int NO       = 4;
  localparam int ROW_CYC  = NI + 2;
  localparam int PASS_LAT = NO * ROW_CYC + 2;
  localparam int PERIOD   = PASS_LAT + 1;
  localparam int BOUND    = 200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mac_layer_sched_if #(.BITSIZE(BITS), .N_IN(NI), .N_OUT(NO)) bus ();

  mac_layer_sched #(.BITSIZE(BITS), .N_IN(NI), .N_OUT(NO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int done_times[$];

  logic [BITS-1:0] x_m [NI];
  logic [BITS-1:0] w_m [NO][NI];
  logic [BITS-1:0] b_m [NO];
  logic [BITS-1:0] exp_y [NO];
  logic [BITS-1:0] old_y [NO];

  always @(negedge clk) begin
    cyc++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_times.push_back(cyc);
    end
    if (bus.busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BITS-1:0] fx_mul(input logic [BITS-1:0] a, input logic [BITS-1:0] c);
    longint p;
    p = longint'($signed(a)) * longint'($signed(c));
    p = p >>> FRAC_BITS;
    return p[BITS-1:0];
  endfunction

  task automatic model_layer();
    logic [BITS-1:0] acc;
    for (int r = 0; r < NO; r++) begin
      acc = b_m[r];
      for (int k = 0; k < NI; k++) acc = acc + fx_mul(x_m[k], w_m[r][k]);
      exp_y[r] = acc;
    end
  endtask

  task automatic drive_bus();
    for (int k = 0; k < NI; k++) bus.x[BITS*k +: BITS] = x_m[k];
    for (int r = 0; r < NO; r++) begin
      bus.b[BITS*r +: BITS] = b_m[r];
      for (int k = 0; k < NI; k++) bus.w[BITS*(r*NI+k) +: BITS] = w_m[r][k];
    end
  endtask

  task automatic random_data();
    for (int k = 0; k < NI; k++) x_m[k] = BITS'($urandom);
    for (int r = 0; r < NO; r++) begin
      b_m[r] = BITS'($urandom);
      for (int k = 0; k < NI; k++) w_m[r][k] = BITS'($urandom);
    end
  endtask

  task automatic check_y(input string tag);
    for (int r = 0; r < NO; r++)
      check($sformatf("%s y[%0d]", tag, r), bus.y[BITS*r +: BITS], exp_y[r]);
  endtask

  // mode 0: plain, 1: scramble inputs after LOAD, 2: start pulses mid-pass,
  // 3: check per-row write timing against old_y/exp_y
  task automatic run_pass(input string tag, input int mode);
    int lat;
    int busy0;
    int done0;
    model_layer();
    drive_bus();
    busy0 = busy_cnt;
    done0 = done_cnt;
    bus.start = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      bus.start = (mode == 2) && (lat == 5 || lat == 10 || lat == 20);
      if (lat == 1) begin
        check({tag, " busy@1"}, bus.busy, 1);
        check({tag, " y_valid@1"}, bus.y_valid, 0);
      end
      if (mode == 1 && lat == 2) begin
        bus.x = {NI{BITS'($urandom)}};
        bus.w = {(NI*NO){BITS'($urandom)}};
        bus.b = {NO{BITS'($urandom)}};
      end
      if (mode == 3) begin
        for (int r = 0; r < NO; r++) begin
          if (lat == 1 + (r + 1) * ROW_CYC)
            check($sformatf("%s pre-write y[%0d]", tag, r), bus.y[BITS*r +: BITS], old_y[r]);
          if (lat == 2 + (r + 1) * ROW_CYC)
            check($sformatf("%s write y[%0d]", tag, r), bus.y[BITS*r +: BITS], exp_y[r]);
        end
      end
      if (bus.done === 1'b1 || lat >= BOUND) break;
    end
    check({tag, " done latency"}, lat, PASS_LAT);
    check({tag, " y_valid@done"}, bus.y_valid, 1);
    check_y(tag);
    @(negedge clk);
    @(negedge clk);
    check({tag, " busy cycles"}, busy_cnt - busy0, PASS_LAT);
    check({tag, " idle busy"}, bus.busy, 0);
    check({tag, " y_valid held"}, bus.y_valid, 1);
    if (mode == 2) repeat (40) @(negedge clk);
    check({tag, " done pulses"}, done_cnt - done0, 1);
  endtask

  initial begin
    int d0;
    int n;
    bus.start = 1'b0;
    bus.x = '0;
    bus.w = '0;
    bus.b = '0;

    // reset and idle
    #1;
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst y_valid", bus.y_valid, 0);
    check("rst y", bus.y, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle done count", done_cnt, 0);
    check("idle busy count", busy_cnt, 0);
    check("idle y", bus.y, 0);
    check("idle y_valid", bus.y_valid, 0);

    // x=0 -> y=b
    random_data();
    for (int k = 0; k < NI; k++) x_m[k] = '0;
    b_m[0] = 20'h00400;
    b_m[1] = 20'hFF800;
    b_m[2] = 20'h01000;
    b_m[3] = 20'h00000;
    run_pass("zero_x", 0);

    // x=1.0, w=0.125*(r+1), b=0, with per-row write timing
    for (int r = 0; r < NO; r++) old_y[r] = exp_y[r];
    for (int k = 0; k < NI; k++) x_m[k] = 20'h01000;
    for (int r = 0; r < NO; r++) begin
      b_m[r] = '0;
      for (int k = 0; k < NI; k++) w_m[r][k] = BITS'(512 * (r + 1));
    end
    run_pass("ramp_w", 3);

    // inputs changed after LOAD
    random_data();
    run_pass("latch", 1);

    // start pulses during pass
    random_data();
    run_pass("mid_start", 2);

    // start held high: back-to-back passes
    random_data();
    model_layer();
    drive_bus();
    d0 = done_times.size();
    bus.start = 1'b1;
    n = 0;
    while (done_times.size() < d0 + 3 && n < 4 * BOUND) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("held pass count", done_times.size() - d0, 3);
    if (done_times.size() >= d0 + 3) begin
      check("held period 1", done_times[d0+1] - done_times[d0], PERIOD);
      check("held period 2", done_times[d0+2] - done_times[d0+1], PERIOD);
    end
    check_y("held");
    repeat (5) @(negedge clk);

    // reset mid-MAC
    random_data();
    drive_bus();
    d0 = done_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre-reset busy", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst busy", bus.busy, 0);
    check("async rst done", bus.done, 0);
    check("async rst y_valid", bus.y_valid, 0);
    check("async rst y", bus.y, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("no done after abort", done_cnt - d0, 0);
    check("no busy after abort", bus.busy, 0);
    run_pass("after_abort", 0);

    // further random passes
    for (int i = 0; i < 3; i++) begin
      random_data();
      run_pass($sformatf("rand%0d", i), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
